// File: rtl/i_decode_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, flush, and the registered ID/EX outputs.
// master = surrounding pipeline (fetch/writeback/execute), slave = i_decode.
`ifndef WORD
`define WORD 32
`endif

interface i_decode_if;
    logic [`WORD-1:0] nPC_id;
    logic [`WORD-1:0] IR_id;
    logic             wb_RegWrite;
    logic [4:0]       wb_WriteReg;
    logic [`WORD-1:0] wb_WriteData;
    logic             flush;
    logic             stall;
    logic [`WORD-1:0] nPC_ex;
    logic [`WORD-1:0] rd1_ex;
    logic [`WORD-1:0] rd2_ex;
    logic [`WORD-1:0] imm_ex;
    logic [4:0]       rt_ex;
    logic [4:0]       rd_ex;
    logic             RegWrite_ex;
    logic             MemtoReg_ex;
    logic             Branch_ex;
    logic             MemRead_ex;
    logic             MemWrite_ex;
    logic             RegDst_ex;
    logic             ALUSrc_ex;
    logic [1:0]       ALUOp_ex;

    modport master (
        output nPC_id, IR_id, wb_RegWrite, wb_WriteReg, wb_WriteData, flush,
        input  stall, nPC_ex, rd1_ex, rd2_ex, imm_ex, rt_ex, rd_ex,
               RegWrite_ex, MemtoReg_ex, Branch_ex, MemRead_ex, MemWrite_ex,
               RegDst_ex, ALUSrc_ex, ALUOp_ex
    );

    modport slave (
        input  nPC_id, IR_id, wb_RegWrite, wb_WriteReg, wb_WriteData, flush,
        output stall, nPC_ex, rd1_ex, rd2_ex, imm_ex, rt_ex, rd_ex,
               RegWrite_ex, MemtoReg_ex, Branch_ex, MemRead_ex, MemWrite_ex,
               RegDst_ex, ALUSrc_ex, ALUOp_ex
    );
endinterface

// File: rtl/i_decode.sv
// Instruction-decode stage: register file, immediate extension, control decode, load-use stall, ID/EX buffer.
// Optional REGFILE_BYPASS_EN: same-cycle writeback data is forwarded onto the register-file read ports.
`ifndef WORD
`define WORD 32
`endif

module i_decode #(
    parameter int unsigned NREG = 32
) (
    input  logic       clk,
    input  logic       reset,
    i_decode_if.slave  bus
);
    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [`WORD-1:0] r_rf [NREG];

    logic [5:0]       w_op;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic [`WORD-1:0] w_imm;
    logic [`WORD-1:0] w_rd1;
    logic [`WORD-1:0] w_rd2;
    ctrl_t            w_ctrl;
    logic             w_uses_rt;
    logic             w_stall;

    logic [`WORD-1:0] r_nPC;
    logic [`WORD-1:0] r_rd1;
    logic [`WORD-1:0] r_rd2;
    logic [`WORD-1:0] r_imm;
    logic [4:0]       r_rt;
    logic [4:0]       r_rd;
    ctrl_t            r_ctrl;

    assign w_op  = bus.IR_id[31:26];
    assign w_rs  = bus.IR_id[25:21];
    assign w_rt  = bus.IR_id[20:16];
    assign w_rd  = bus.IR_id[15:11];
    assign w_imm = {{(`WORD-16){bus.IR_id[15]}}, bus.IR_id[15:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (bus.wb_RegWrite && bus.wb_WriteReg != 5'd0) begin
            r_rf[bus.wb_WriteReg] <= bus.wb_WriteData;
        end
    end

    always_comb begin
        w_rd1 = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
        w_rd2 = (w_rt == 5'd0) ? '0 : r_rf[w_rt];
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_RegWrite && bus.wb_WriteReg == w_rs && w_rs != 5'd0) begin
            w_rd1 = bus.wb_WriteData;
        end
        if (bus.wb_RegWrite && bus.wb_WriteReg == w_rt && w_rt != 5'd0) begin
            w_rd2 = bus.wb_WriteData;
        end
`endif
    end

    always_comb begin
        w_ctrl    = '0;
        w_uses_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = 2'b10;
                w_uses_rt        = 1'b1;
            end
            OP_LW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.memto_reg = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.mem_read  = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.branch    = 1'b1;
                w_ctrl.alu_op    = 2'b01;
                w_uses_rt        = 1'b1;
            end
            default: begin
                w_ctrl    = '0;
                w_uses_rt = 1'b0;
            end
        endcase
    end

    // A load in EX whose target feeds this instruction; the bubble it causes clears MemRead_ex and releases it.
    assign w_stall = !reset && r_ctrl.mem_read && (r_rt != 5'd0) &&
                     ((r_rt == w_rs) || (w_uses_rt && (r_rt == w_rt)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nPC  <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_rt   <= '0;
            r_rd   <= '0;
            r_ctrl <= '0;
        end else begin
            r_nPC  <= bus.nPC_id;
            r_rd1  <= w_rd1;
            r_rd2  <= w_rd2;
            r_imm  <= w_imm;
            r_rt   <= w_rt;
            r_rd   <= w_rd;
            r_ctrl <= (bus.flush || w_stall) ? '0 : w_ctrl;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.nPC_ex      = r_nPC;
    assign bus.rd1_ex      = r_rd1;
    assign bus.rd2_ex      = r_rd2;
    assign bus.imm_ex      = r_imm;
    assign bus.rt_ex       = r_rt;
    assign bus.rd_ex       = r_rd;
    assign bus.RegWrite_ex = r_ctrl.reg_write;
    assign bus.MemtoReg_ex = r_ctrl.memto_reg;
    assign bus.Branch_ex   = r_ctrl.branch;
    assign bus.MemRead_ex  = r_ctrl.mem_read;
    assign bus.MemWrite_ex = r_ctrl.mem_write;
    assign bus.RegDst_ex   = r_ctrl.reg_dst;
    assign bus.ALUSrc_ex   = r_ctrl.alu_src;
    assign bus.ALUOp_ex    = r_ctrl.alu_op;
endmodule

// File: tb/tb_i_decode.sv
// Directed bench for i_decode: vector table for single-cycle decode, hand sequences for stall/flush/reset/bypass.
module tb_i_decode;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    i_decode_if bus ();

    i_decode #(.NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl packing: {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, ALUOp[1:0]}
    localparam logic [8:0] C_NOP = 9'b000000000;
    localparam logic [8:0] C_R   = 9'b100001010;
    localparam logic [8:0] C_LW  = 9'b110100100;
    localparam logic [8:0] C_SW  = 9'b000010100;
    localparam logic [8:0] C_BEQ = 9'b001000001;
    localparam logic [31:0] IR_NOP = 32'hFC00_0000;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        stall;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [8:0]  ctrl;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [8:0] ctrl_now();
        return {bus.RegWrite_ex, bus.MemtoReg_ex, bus.Branch_ex, bus.MemRead_ex, bus.MemWrite_ex,
                bus.RegDst_ex, bus.ALUSrc_ex, bus.ALUOp_ex};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idex(input string tag, input logic [31:0] npc, input logic [31:0] rd1,
                            input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [8:0] ctrl);
        chk({tag, ".nPC"}, bus.nPC_ex, npc);
        chk({tag, ".rd1"}, bus.rd1_ex, rd1);
        chk({tag, ".rd2"}, bus.rd2_ex, rd2);
        chk({tag, ".imm"}, bus.imm_ex, imm);
        chk({tag, ".rt"}, {27'd0, bus.rt_ex}, {27'd0, rt});
        chk({tag, ".rd"}, {27'd0, bus.rd_ex}, {27'd0, rd});
        chk({tag, ".ctrl"}, {23'd0, ctrl_now()}, {23'd0, ctrl});
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic flush,
                         input logic wb_en, input logic [4:0] wb_reg, input logic [31:0] wb_data);
        bus.IR_id        = ir;
        bus.nPC_id       = npc;
        bus.flush        = flush;
        bus.wb_RegWrite  = wb_en;
        bus.wb_WriteReg  = wb_reg;
        bus.wb_WriteData = wb_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_same;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(itype(6'b100011, 5'd1, 5'd2, 16'hFFFC), 32'h0000_1234, 1'b0, 1'b0, 5'd0, '0);

        vecs[0] = '{IR_NOP, 32'h0040_0000, 1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0,
                    32'h0, 32'h0, 32'h0, 5'd0, 5'd0, C_NOP};
        vecs[1] = '{rtype(5'd0, 5'd5, 5'd4), 32'h0040_0004, 1'b0, 1'b1, 5'd1, 32'h1111_1111, 1'b0,
                    32'h0, 32'hDEAD_BEEF, 32'h0000_2020, 5'd5, 5'd4, C_R};
        vecs[2] = '{itype(6'b101011, 5'd5, 5'd1, 16'h0008), 32'h0040_0008, 1'b0, 1'b1, 5'd9, 32'h8000_0001, 1'b0,
                    32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0008, 5'd1, 5'd0, C_SW};
        vecs[3] = '{itype(6'b000100, 5'd9, 5'd1, 16'hFFFF), 32'h0040_000C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
                    32'h8000_0001, 32'h1111_1111, 32'hFFFF_FFFF, 5'd1, 5'd31, C_BEQ};
        vecs[4] = '{itype(6'b001000, 5'd1, 5'd9, 16'h7FFF), 32'h0040_0010, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
                    32'h1111_1111, 32'h8000_0001, 32'h0000_7FFF, 5'd9, 5'd15, C_NOP};
        vecs[5] = '{rtype(5'd5, 5'd9, 5'd2), 32'h0040_0014, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0,
                    32'hDEAD_BEEF, 32'h8000_0001, 32'h0000_1020, 5'd9, 5'd2, C_NOP};
        vecs[6] = '{itype(6'b100011, 5'd1, 5'd2, 16'hFFFC), 32'h0040_0018, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
                    32'h1111_1111, 32'h0, 32'hFFFF_FFFC, 5'd2, 5'd31, C_LW};

        // reset
        step();
        step();
        chk("reset.stall", {31'd0, bus.stall}, 32'd0);
        chk_idex("reset", '0, '0, '0, '0, 5'd0, 5'd0, C_NOP);
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            drive(rtype(5'(r), 5'(r), 5'd3), 32'h0, 1'b0, 1'b0, 5'd0, '0);
            step();
            chk($sformatf("rfclear.rs%0d", r), bus.rd1_ex, 32'h0);
            chk($sformatf("rfclear.rt%0d", r), bus.rd2_ex, 32'h0);
        end

        // write $5 then read it via add $3,$5,$0
        drive(IR_NOP, 32'h0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        drive(rtype(5'd5, 5'd0, 5'd3), 32'h0000_0100, 1'b0, 1'b0, 5'd0, '0);
        step();
        chk_idex("wr_rd", 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 32'h0000_1820, 5'd0, 5'd3, C_R);

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].ir, vecs[i].npc, vecs[i].flush, vecs[i].wb_en, vecs[i].wb_reg, vecs[i].wb_data);
            #1;
            chk($sformatf("vec%0d.stall", i), {31'd0, bus.stall}, {31'd0, vecs[i].stall});
            step();
            chk_idex($sformatf("vec%0d", i), vecs[i].npc, vecs[i].rd1, vecs[i].rd2, vecs[i].imm,
                     vecs[i].rt, vecs[i].rd, vecs[i].ctrl);
        end

        // load-use: lw $2 now in ID/EX, add $4,$2,$2 must stall exactly one cycle
        drive(rtype(5'd2, 5'd2, 5'd4), 32'h0040_001C, 1'b0, 1'b0, 5'd0, '0);
        #1;
        chk("lu.stall_on", {31'd0, bus.stall}, 32'd1);
        step();
        chk_idex("lu.bubble", 32'h0040_001C, 32'h0, 32'h0, 32'h0000_2020, 5'd2, 5'd4, C_NOP);
        chk("lu.stall_off", {31'd0, bus.stall}, 32'd0);
        step();
        chk_idex("lu.issue", 32'h0040_001C, 32'h0, 32'h0, 32'h0000_2020, 5'd2, 5'd4, C_R);

        // flush together with a load-use stall
        drive(itype(6'b100011, 5'd1, 5'd2, 16'hFFFC), 32'h0040_0020, 1'b0, 1'b0, 5'd0, '0);
        step();
        drive(rtype(5'd2, 5'd2, 5'd4), 32'h0040_0024, 1'b1, 1'b0, 5'd0, '0);
        #1;
        chk("fl.stall_on", {31'd0, bus.stall}, 32'd1);
        step();
        chk_idex("fl", 32'h0040_0024, 32'h0, 32'h0, 32'h0000_2020, 5'd2, 5'd4, C_NOP);
        chk("fl.noX", {31'd0, $isunknown({bus.stall, bus.nPC_ex, bus.rd1_ex, bus.rd2_ex, bus.imm_ex,
                                          bus.rt_ex, bus.rd_ex, ctrl_now()})}, 32'd0);

        // lw $0 never stalls
        drive(itype(6'b100011, 5'd1, 5'd0, 16'h0000), 32'h0040_0028, 1'b0, 1'b0, 5'd0, '0);
        step();
        drive(rtype(5'd0, 5'd0, 5'd4), 32'h0040_002C, 1'b0, 1'b0, 5'd0, '0);
        #1;
        chk("lw0.stall", {31'd0, bus.stall}, 32'd0);
        step();
        chk("lw0.ctrl", {23'd0, ctrl_now()}, {23'd0, C_R});

        // lw rt match on a consumer that ignores rt: no stall; sw does use rt: stall
        drive(itype(6'b100011, 5'd1, 5'd2, 16'hFFFC), 32'h0040_0030, 1'b0, 1'b0, 5'd0, '0);
        step();
        drive(itype(6'b100011, 5'd3, 5'd2, 16'h0000), 32'h0040_0034, 1'b0, 1'b0, 5'd0, '0);
        #1;
        chk("lwlw.stall", {31'd0, bus.stall}, 32'd0);
        step();
        chk("lwlw.ctrl", {23'd0, ctrl_now()}, {23'd0, C_LW});
        drive(itype(6'b101011, 5'd3, 5'd2, 16'h0000), 32'h0040_0038, 1'b0, 1'b0, 5'd0, '0);
        #1;
        chk("lwsw.stall", {31'd0, bus.stall}, 32'd1);
        step();
        chk("lwsw.ctrl", {23'd0, ctrl_now()}, {23'd0, C_NOP});

        // same-cycle writeback and read of $7
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h0000_A5A5;
`else
        exp_same = 32'h0;
`endif
        drive(rtype(5'd7, 5'd0, 5'd8), 32'h0040_003C, 1'b0, 1'b1, 5'd7, 32'h0000_A5A5);
        step();
        chk("byp.same", bus.rd1_ex, exp_same);
        drive(rtype(5'd7, 5'd0, 5'd8), 32'h0040_003C, 1'b0, 1'b0, 5'd0, '0);
        step();
        chk("byp.next", bus.rd1_ex, 32'h0000_A5A5);

        // reset asserted mid-stall
        drive(itype(6'b100011, 5'd1, 5'd2, 16'hFFFC), 32'h0040_0040, 1'b0, 1'b0, 5'd0, '0);
        step();
        drive(rtype(5'd2, 5'd2, 5'd4), 32'h0040_0044, 1'b0, 1'b0, 5'd0, '0);
        #1;
        chk("rst.stall_pre", {31'd0, bus.stall}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst.stall_forced", {31'd0, bus.stall}, 32'd0);
        step();
        chk_idex("rst.mid", '0, '0, '0, '0, 5'd0, 5'd0, C_NOP);
        reset = 1'b0;
        drive(rtype(5'd7, 5'd0, 5'd8), 32'h0040_0048, 1'b0, 1'b0, 5'd0, '0);
        step();
        chk("rst.rf7", bus.rd1_ex, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
